raster_window_gate: RTL and testbench
=====================================

# raster_window_gate

Parametrised raster window gate for the pixel stream ahead of feature detection. Tracks column/row position of every accepted input beat across a full raster including blanking. Forwards only pixels inside a runtime-positioned ACTIVE_COLS x ACTIVE_ROWS window, through a registered valid/ready output stage with frame and line markers. Successor to the fixed 800x600 blanking gate: adds configurable geometry, window offset, backpressure, resync and a frame counter.

## Interface
- DATA_WIDTH, 8, pixel width
- TOTAL_COLS, 1201, beats per raster line including blanking
- TOTAL_ROWS, 1201, lines per raster frame including blanking
- ACTIVE_COLS, 800, window width
- ACTIVE_ROWS, 600, window height
- CNT_WIDTH, 13, width of col/row counters and window origin inputs
- FRAME_WIDTH, 16, width of frame counter

- clock  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = forward window pixels; 0 = consume and discard all beats
- win_x  in  CNT_WIDTH  window column origin, sampled at frame start
- win_y  in  CNT_WIDTH  window row origin, sampled at frame start
- in_valid  in  1  input beat present
- in_sof  in  1  input beat is raster position (0,0); resync
- in_data  in  DATA_WIDTH  input pixel
- in_ready  out  1  input beat accepted when in_valid && in_ready
- out_valid  out  1  output beat present
- out_data  out  DATA_WIDTH  output pixel; 0 when out_valid = 0
- out_sof  out  1  beat is window (0,0)
- out_eol  out  1  beat is last column of a window line
- out_eof  out  1  beat is last pixel of window
- out_ready  in  1  downstream accepts output beat
- frame_count  out  FRAME_WIDTH  completed frames, wraps modulo 2^FRAME_WIDTH

## Operation
- Position counters col, row (CNT_WIDTH) advance only on accepted beat (accept = in_valid && in_ready). Beat's own position is (col,row), or (0,0) if in_sof = 1.
- Advance: col+1; at col = TOTAL_COLS-1, col <- 0 and row+1; at row = TOTAL_ROWS-1 too, row <- 0. No dead cycle at wrap.
- in_sof on accepted beat: beat treated as (0,0); next position (1,0). If counters were not already (0,0), frame_count does not increment for the truncated frame.
- Frame end: accepted beat at (TOTAL_COLS-1, TOTAL_ROWS-1) increments frame_count.
- Window origin wx, wy: latched from win_x/win_y at reset release, at frame end, and on accepted in_sof beat (latched value applies to that beat). Stable for the whole frame.
- In window: col-wx and row-wy in [0,ACTIVE_COLS) and [0,ACTIVE_ROWS), computed at CNT_WIDTH+1 bits unsigned so no wrap. Window parts beyond TOTAL_COLS/TOTAL_ROWS are clipped; out_eol/out_eof are then never asserted for the clipped part.
- Forwarded beat: in window and enable = 1. Others are discarded, in_ready = 1 for them regardless of output stage.
- Output register: one entry. On forwarded accept, load data and markers, out_valid <- 1. Clear out_valid when out_ready && out_valid and no new load. Load and drain may occur in the same cycle.
- in_ready = 1 when current beat is discarded, else (!out_valid || out_ready). Combinational from position, enable, out_valid, out_ready only; never from in_valid.
- Markers: out_sof at window (0,0); out_eol at window col ACTIVE_COLS-1; out_eof at (ACTIVE_COLS-1, ACTIVE_ROWS-1). Markers and out_data are 0 whenever out_valid = 0.
- enable change takes effect on the next beat; a beat already in the output register still drains.

## Timing
- Reset (reset_n low, async): col = row = 0, out_valid = 0, out_data = 0, all markers 0, frame_count = 0, wx = wy = 0. After release, in_ready = 1.
- Latency: forwarded beat accepted at cycle N appears on out_valid/out_data at cycle N+1.
- Throughput: one beat per cycle when out_ready held high.
- Backpressure: out_valid && !out_ready holds out_data and markers stable. in_ready = 0 for window beats; blanking beats still accepted and discarded.
- reset_n asserted mid-frame: output beat lost, counters to (0,0), no frame_count increment.

## Test plan
- TOTAL 8x6, ACTIVE 4x3, win (2,1), out_ready=1, 48 continuous beats data=index -> 12 outputs, data 10,11,12,13,18..21,26..29. out_sof on 10, out_eol on 13/21/29, out_eof on 29. frame_count 0->1 after beat 47.
- Same, out_ready toggled 1-0 per cycle -> identical output sequence. No drops or duplicates. out_data stable while stalled. Blanking beats accepted during stalls.
- in_sof at beat 20 of frame -> that beat treated as (0,0). Next window output is beat 30 (position (2,1)). frame_count unchanged at resync.
- win (6,4), ACTIVE 4x3 -> outputs only cols 6-7, rows 4-5. No out_eol, no out_eof. frame_count still increments.
- enable=0 for a full frame -> out_valid never 1, in_ready constantly 1, frame_count increments.
- reset_n pulsed low mid-window with out_valid=1 -> out_valid and markers 0 immediately. Next beat after release treated as (0,0).

Source files
------------

// File: rtl/raster_window_gate.sv
// Raster window gate: tracks raster position of accepted beats and
// forwards pixels inside a movable window through a one-entry output stage.
module raster_window_gate #(
  parameter int DATA_WIDTH  = 8,
  parameter int TOTAL_COLS  = 1201,
  parameter int TOTAL_ROWS  = 1201,
  parameter int ACTIVE_COLS = 800,
  parameter int ACTIVE_ROWS = 600,
  parameter int CNT_WIDTH   = 13,
  parameter int FRAME_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [CNT_WIDTH-1:0]   win_x,
  input  logic [CNT_WIDTH-1:0]   win_y,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_sof,
  output logic                   out_eol,
  output logic                   out_eof,
  input  logic                   out_ready,
  output logic [FRAME_WIDTH-1:0] frame_count
);

  localparam int CW1 = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(TOTAL_COLS - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(TOTAL_ROWS - 1);
  localparam logic [CW1-1:0] ACOLS = CW1'(ACTIVE_COLS);
  localparam logic [CW1-1:0] AROWS = CW1'(ACTIVE_ROWS);
  localparam logic [CW1-1:0] ACOL_LAST = CW1'(ACTIVE_COLS - 1);
  localparam logic [CW1-1:0] AROW_LAST = CW1'(ACTIVE_ROWS - 1);

  logic [CNT_WIDTH-1:0] col, row;
  logic [CNT_WIDTH-1:0] wx, wy;
  logic                 pend;
  logic [CNT_WIDTH-1:0] pcol, prow;
  logic [CNT_WIDTH-1:0] ox, oy;
  logic [CW1-1:0]       dx, dy;
  logic                 in_win;
  logic                 fwd;
  logic                 accept;
  logic                 frame_end;

  // Position and window test of the beat currently on the input.
  // pend covers the first cycle after reset, before wx/wy are latched.
  always_comb begin
    pcol      = in_sof ? '0 : col;
    prow      = in_sof ? '0 : row;
    ox        = (in_sof || pend) ? win_x : wx;
    oy        = (in_sof || pend) ? win_y : wy;
    dx        = {1'b0, pcol} - {1'b0, ox};
    dy        = {1'b0, prow} - {1'b0, oy};
    in_win    = (dx < ACOLS) && (dy < AROWS);
    fwd       = in_win && enable;
    in_ready  = !fwd || !out_valid || out_ready;
    accept    = in_valid && in_ready;
    frame_end = (pcol == COL_LAST) && (prow == ROW_LAST);
  end

  // Raster position counters, advanced once per accepted beat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (pcol == COL_LAST) begin
        col <= '0;
        row <= (prow == ROW_LAST) ? '0 : prow + 1'b1;
      end else begin
        col <= pcol + 1'b1;
        row <= prow;
      end
    end
  end

  // Window origin, held constant for a whole frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wx   <= '0;
      wy   <= '0;
      pend <= 1'b1;
    end else begin
      pend <= 1'b0;
      if (pend || (accept && (in_sof || frame_end))) begin
        wx <= win_x;
        wy <= win_y;
      end
    end
  end

  // Completed frames; a resync-truncated frame never reaches frame_end.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      frame_count <= '0;
    else if (accept && frame_end)
      frame_count <= frame_count + 1'b1;
  end

  // One-entry output register; payload is zeroed whenever it is empty.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (accept && fwd) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_sof   <= (dx == '0) && (dy == '0);
      out_eol   <= (dx == ACOL_LAST);
      out_eof   <= (dx == ACOL_LAST) && (dy == AROW_LAST);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_raster_window_gate.sv
// Bench for raster_window_gate: directed raster tables plus randomized
// traffic checked against an integer-position scoreboard model.
module tb_raster_window_gate;

  localparam int DW = 8;
  localparam int TC = 8;
  localparam int TR = 6;
  localparam int AC = 4;
  localparam int AR = 3;
  localparam int CW = 13;
  localparam int FW = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b1;
  logic [CW-1:0] win_x = 13'd2;
  logic [CW-1:0] win_y = 13'd1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          out_eol;
  logic          out_eof;
  logic          out_ready = 1'b1;
  logic [FW-1:0] frame_count;

  raster_window_gate #(
    .DATA_WIDTH(DW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
    .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .CNT_WIDTH(CW), .FRAME_WIDTH(FW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .win_x(win_x), .win_y(win_y),
    .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .out_ready(out_ready), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       l;
    logic       f;
  } beat_t;

  typedef struct {
    int         idx;
    logic [7:0] d;
    logic       s;
    logic       l;
    logic       f;
  } vec_t;

  int    errors = 0;
  int    checks = 0;
  beat_t expq[$];
  beat_t got[$];
  int    mc, mr, mwx, mwy, mfc;
  vec_t  tbl[12];

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // One clock: drive at posedge+1, check and model at posedge-2.
  task automatic step(input bit v, input bit s, input logic [7:0] d,
                      input bit r, output bit acc);
    beat_t cur;
    bit    mv, inwin, rdy;
    int    pc, pr, ox, oy;
    in_valid = v;
    in_sof = s;
    in_data = d;
    out_ready = r;
    #7;
    pc = s ? 0 : mc;
    pr = s ? 0 : mr;
    ox = s ? int'(win_x) : mwx;
    oy = s ? int'(win_y) : mwy;
    inwin = pc >= ox && pc < ox + AC && pr >= oy && pr < oy + AR;
    mv = expq.size() != 0;
    rdy = !(inwin && enable) || !mv || r;
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, mv);
    chk("frame_count", frame_count, mfc);
    cur = {out_data, out_sof, out_eol, out_eof};
    if (mv) begin
      chk("out_beat", cur, expq[0]);
      if (r) begin
        got.push_back(cur);
        void'(expq.pop_front());
      end
    end else begin
      chk("idle_zero", cur, 0);
    end
    acc = v && rdy;
    if (acc) begin
      if (s) begin
        mwx = ox;
        mwy = oy;
      end
      if (inwin && enable)
        expq.push_back({d, pc == ox && pr == oy, pc == ox + AC - 1,
                        pc == ox + AC - 1 && pr == oy + AR - 1});
      if (pc == TC - 1 && pr == TR - 1) begin
        mfc = (mfc + 1) % 65536;
        mwx = win_x;
        mwy = win_y;
      end
      pc++;
      if (pc == TC) begin
        pc = 0;
        pr = (pr + 1) % TR;
      end
      mc = pc;
      mr = pr;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_sof = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_marks", {out_sof, out_eol, out_eof}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_fc", frame_count, 0);
    expq.delete();
    mc = 0;
    mr = 0;
    mfc = 0;
    mwx = win_x;
    mwy = win_y;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // n beats of data base+i; rmode 1 toggles out_ready each cycle.
  task automatic feed(input int n, input int base, input int rmode,
                      input int sof_at);
    bit acc;
    int i = 0;
    int k = 0;
    while (i < n && k < 20 * n + 100) begin
      step(1'b1, i == sof_at, 8'(base + i),
           rmode == 0 ? 1'b1 : (k % 2 == 0), acc);
      if (acc) i++;
      k++;
    end
    chk("feed_done", i, n);
  endtask

  task automatic drain();
    bit acc;
    repeat (4) step(1'b0, 1'b0, 8'd0, 1'b1, acc);
  endtask

  task automatic check_table(input string n);
    chk({n, "_count"}, got.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < got.size())
        chk(n, got[i], {tbl[i].d, tbl[i].s, tbl[i].l, tbl[i].f});
  endtask

  initial begin
    bit acc;
    int fc0;
    bit anym;
    tbl = '{
      '{10, 8'd10, 1, 0, 0}, '{11, 8'd11, 0, 0, 0},
      '{12, 8'd12, 0, 0, 0}, '{13, 8'd13, 0, 1, 0},
      '{18, 8'd18, 0, 0, 0}, '{19, 8'd19, 0, 0, 0},
      '{20, 8'd20, 0, 0, 0}, '{21, 8'd21, 0, 1, 0},
      '{26, 8'd26, 0, 0, 0}, '{27, 8'd27, 0, 0, 0},
      '{28, 8'd28, 0, 0, 0}, '{29, 8'd29, 0, 1, 1}
    };

    do_reset();
    chk("rst_ready", in_ready, 1);

    // Full frame, no backpressure.
    got.delete();
    feed(48, 0, 0, -1);
    drain();
    check_table("frame_plain");
    chk("fc_after_frame1", frame_count, 1);

    // Same frame with out_ready toggling.
    got.delete();
    feed(48, 0, 1, -1);
    drain();
    check_table("frame_stall");
    chk("fc_after_frame2", frame_count, 2);

    // Resync at beat 20 of a frame.
    got.delete();
    feed(20, 0, 0, -1);
    fc0 = mfc;
    step(1'b1, 1'b1, 8'd20, 1'b1, acc);
    chk("sof_fc_hold", frame_count, fc0);
    feed(47, 21, 0, -1);
    drain();
    chk("sof_count", got.size(), 18);
    if (got.size() > 6) chk("sof_first_after", got[6].d, 30);
    chk("sof_fc_after", frame_count, fc0 + 1);

    // Window clipped by the raster edge.
    win_x = 13'd6;
    win_y = 13'd4;
    do_reset();
    got.delete();
    feed(48, 0, 0, -1);
    drain();
    chk("clip_count", got.size(), 4);
    anym = 1'b0;
    foreach (got[i]) anym |= got[i].l | got[i].f;
    chk("clip_no_eol_eof", anym, 0);
    if (got.size() > 0) chk("clip_first", got[0], {8'd38, 3'b100});
    chk("clip_fc", frame_count, 1);

    // Disabled for a full frame.
    enable = 1'b0;
    got.delete();
    fc0 = mfc;
    feed(48, 0, 1, -1);
    drain();
    chk("dis_count", got.size(), 0);
    chk("dis_fc", frame_count, fc0 + 1);
    enable = 1'b1;

    // Reset while a window beat sits stalled in the output register.
    win_x = 13'd2;
    win_y = 13'd1;
    do_reset();
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'(i), 1'b0, acc);
    step(1'b0, 1'b0, 8'd0, 1'b0, acc);
    chk("pre_rst_sof", {out_valid, out_sof}, 2'b11);
    do_reset();
    got.delete();
    feed(48, 0, 0, -1);
    drain();
    check_table("post_reset");

    // Randomized traffic against the scoreboard.
    for (int t = 0; t < 5; t++) begin
      win_x = 13'($urandom_range(0, 7));
      win_y = 13'($urandom_range(0, 5));
      do_reset();
      for (int c = 0; c < 800; c++) begin
        if ($urandom_range(0, 31) == 0) enable = ~enable;
        step($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
             8'($urandom), $urandom_range(0, 2) != 0, acc);
      end
      drain();
      chk("rand_sb_empty", expq.size(), 0);
      enable = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
